// File: rtl/reg_file_sb.sv
// Parametrised register file with async reset, per-port write-to-read bypass and
// a per-register busy scoreboard that drives per-port hazard flags.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rf_en,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rs_busy,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREGS-1:0]    busy_vec
);

    logic [NREGS-1:0][XLEN-1:0] reg_q;
    logic [NREGS-1:0]           busy_q;
    logic                       wr_valid;

    // A write to register 0 is a no-op everywhere, so qualify it once here.
    assign wr_valid = rf_en && (rd != '0);

    assign reg_q[0]  = '0;
    assign busy_q[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [XLEN-1:0] data_reg;
            logic            busy_reg;
            logic            wr_hit;
            logic            issue_hit;

            assign wr_hit    = wr_valid && (rd == AW'(gi));
            assign issue_hit = issue_en && (issue_rd == AW'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (wr_hit) begin
                    data_reg <= wdata;
                end
            end

            // A new producer issuing on the same edge supersedes the retiring one.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    busy_reg <= 1'b0;
                end else if (issue_hit) begin
                    busy_reg <= 1'b1;
                end else if (wr_hit) begin
                    busy_reg <= 1'b0;
                end
            end

            assign reg_q[gi]  = data_reg;
            assign busy_q[gi] = busy_reg;
        end

        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [AW-1:0] addr;
            logic          fwd;

            assign addr = rs[gi*AW +: AW];
            assign fwd  = (BYPASS != 0) && wr_valid && (rd == addr);

            assign rdata[gi*XLEN +: XLEN] = fwd ? wdata : reg_q[addr];
            // Forwarded data resolves the hazard in the same cycle.
            assign rs_busy[gi] = busy_q[addr] && !fwd;
        end
    endgenerate

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three instances (bypass, no bypass, 64x16x3) share one
// stimulus stream and are checked against an array-based reference model.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic        rf_en;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic [4:0]  rs0, rs1, rs2;
    logic        issue_en;
    logic [4:0]  issue_rd;

    logic [63:0]  rdata_a, rdata_b;
    logic [1:0]   rs_busy_a, rs_busy_b;
    logic [31:0]  busy_vec_a, busy_vec_b;
    logic [191:0] rdata_c;
    logic [2:0]   rs_busy_c;
    logic [15:0]  busy_vec_c;

    int n_cmp;
    int n_mis;

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rf_en(rf_en), .rd(rd), .wdata(wdata[31:0]),
        .rs({rs1, rs0}), .rdata(rdata_a), .rs_busy(rs_busy_a),
        .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_vec_a));

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rf_en(rf_en), .rd(rd), .wdata(wdata[31:0]),
        .rs({rs1, rs0}), .rdata(rdata_b), .rs_busy(rs_busy_b),
        .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_vec_b));

    reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .rf_en(rf_en), .rd(rd[3:0]), .wdata(wdata),
        .rs({rs2[3:0], rs1[3:0], rs0[3:0]}), .rdata(rdata_c), .rs_busy(rs_busy_c),
        .issue_en(issue_en), .issue_rd(issue_rd[3:0]), .busy_vec(busy_vec_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: k=0 bypass 32x32, k=1 no bypass 32x32, k=2 bypass 64x16.
    logic [63:0] m_reg  [3][32];
    bit          m_busy [3][32];

    function automatic int nregs(int k); return (k == 2) ? 16 : 32; endfunction
    function automatic int nrd(int k); return (k == 2) ? 3 : 2; endfunction
    function automatic bit byp(int k); return k != 1; endfunction
    function automatic logic [63:0] dmask(int k);
        return (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic int rsel(int p);
        if (p == 0) return int'(rs0);
        if (p == 1) return int'(rs1);
        return int'(rs2);
    endfunction

    function automatic logic [63:0] exp_rdata(int k, int p);
        int a = rsel(p) % nregs(k);
        int w = int'(rd) % nregs(k);
        if (a == 0) return 64'h0;
        if (byp(k) && rf_en && w == a) return wdata & dmask(k);
        return m_reg[k][a];
    endfunction

    function automatic bit exp_rs_busy(int k, int p);
        int a = rsel(p) % nregs(k);
        int w = int'(rd) % nregs(k);
        if (a == 0) return 1'b0;
        return m_busy[k][a] && !(byp(k) && rf_en && w == a);
    endfunction

    function automatic logic [31:0] exp_busy_vec(int k);
        logic [31:0] v = '0;
        for (int r = 0; r < nregs(k); r++) v[r] = m_busy[k][r];
        return v;
    endfunction

    function automatic logic [63:0] get_rdata(int k, int p);
        if (k == 0) return {32'h0, rdata_a[p*32 +: 32]};
        if (k == 1) return {32'h0, rdata_b[p*32 +: 32]};
        return rdata_c[p*64 +: 64];
    endfunction

    function automatic bit get_rs_busy(int k, int p);
        if (k == 0) return rs_busy_a[p];
        if (k == 1) return rs_busy_b[p];
        return rs_busy_c[p];
    endfunction

    function automatic logic [31:0] get_busy_vec(int k);
        if (k == 0) return busy_vec_a;
        if (k == 1) return busy_vec_b;
        return {16'h0, busy_vec_c};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 32; r++) begin
                m_reg[k][r]  = '0;
                m_busy[k][r] = 1'b0;
            end
    endtask

    // Retire first, then issue, so a same-edge issue leaves the register busy.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int w = int'(rd) % nregs(k);
            int i = int'(issue_rd) % nregs(k);
            if (rf_en && w != 0) begin
                m_reg[k][w]  = wdata & dmask(k);
                m_busy[k][w] = 1'b0;
            end
            if (issue_en && i != 0) m_busy[k][i] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rf_en = 1'b0; rd = '0; wdata = '0; issue_en = 1'b0; issue_rd = '0;
    endtask

    task automatic test_reset();
        rs0 = 5'd5; rs1 = 5'd31; rs2 = 5'd15;
        #1;
        n_cmp++; if (busy_vec_a !== 32'h0) begin n_mis++; $display("FAIL rst_busy_vec_a: got %h exp %h", busy_vec_a, 32'h0); end
        n_cmp++; if (busy_vec_c !== 16'h0) begin n_mis++; $display("FAIL rst_busy_vec_c: got %h exp %h", busy_vec_c, 16'h0); end
        n_cmp++; if (rdata_a !== 64'h0) begin n_mis++; $display("FAIL rst_rdata_a: got %h exp %h", rdata_a, 64'h0); end
        n_cmp++; if (rdata_c !== 192'h0) begin n_mis++; $display("FAIL rst_rdata_c: got %h exp %h", rdata_c, 192'h0); end
        n_cmp++; if (rs_busy_b !== 2'b00) begin n_mis++; $display("FAIL rst_rs_busy_b: got %b exp %b", rs_busy_b, 2'b00); end
        rf_en = 1'b1; rd = 5'd5; wdata = 64'h0000_0000_DEAD_BEEF; issue_en = 1'b1; issue_rd = 5'd5;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rdata_b[31:0] !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL pre_rst_rdata_b: got %h exp %h", rdata_b[31:0], 32'hDEAD_BEEF); end
        n_cmp++; if (busy_vec_a[5] !== 1'b1) begin n_mis++; $display("FAIL pre_rst_busy5: got %b exp %b", busy_vec_a[5], 1'b1); end
        // Assert reset between clock edges; outputs must clear with no edge.
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (rdata_a[31:0] !== 32'h0) begin n_mis++; $display("FAIL async_rst_rdata_a: got %h exp %h", rdata_a[31:0], 32'h0); end
        n_cmp++; if (rdata_c[63:0] !== 64'h0) begin n_mis++; $display("FAIL async_rst_rdata_c: got %h exp %h", rdata_c[63:0], 64'h0); end
        n_cmp++; if (busy_vec_a !== 32'h0) begin n_mis++; $display("FAIL async_rst_busy_vec: got %h exp %h", busy_vec_a, 32'h0); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (rdata_b[31:0] !== 32'h0) begin n_mis++; $display("FAIL post_rst_rdata_b: got %h exp %h", rdata_b[31:0], 32'h0); end
        @(negedge clk);
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_mis);
    endtask

    task automatic test_write_read();
        rs0 = 5'd7; rs1 = 5'd0; rs2 = 5'd0;
        rf_en = 1'b1; rd = 5'd7; wdata = 64'h0000_0000_1234_5678;
        #1;
        n_cmp++; if (rdata_b[31:0] !== 32'h0) begin n_mis++; $display("FAIL wr_old_b: got %h exp %h", rdata_b[31:0], 32'h0); end
        n_cmp++; if (rdata_a[31:0] !== 32'h1234_5678) begin n_mis++; $display("FAIL wr_fwd_a: got %h exp %h", rdata_a[31:0], 32'h1234_5678); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rdata_b[31:0] !== 32'h1234_5678) begin n_mis++; $display("FAIL wr_next_b: got %h exp %h", rdata_b[31:0], 32'h1234_5678); end
        n_cmp++; if (rdata_c[63:0] !== 64'h1234_5678) begin n_mis++; $display("FAIL wr_next_c: got %h exp %h", rdata_c[63:0], 64'h1234_5678); end
        @(negedge clk);
        rs0 = 5'd0; rf_en = 1'b1; rd = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        n_cmp++; if (rdata_a[31:0] !== 32'h0) begin n_mis++; $display("FAIL r0_fwd_a: got %h exp %h", rdata_a[31:0], 32'h0); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rdata_b[31:0] !== 32'h0) begin n_mis++; $display("FAIL r0_b: got %h exp %h", rdata_b[31:0], 32'h0); end
        n_cmp++; if (rdata_c[63:0] !== 64'h0) begin n_mis++; $display("FAIL r0_c: got %h exp %h", rdata_c[63:0], 64'h0); end
        @(negedge clk);
        $display("test_write_read done: compared=%0d mismatched=%0d", n_cmp, n_mis);
    endtask

    task automatic test_bypass();
        issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        idle_inputs();
        rs0 = 5'd3; rs1 = 5'd3; rs2 = 5'd3;
        #1;
        n_cmp++; if (rs_busy_a !== 2'b11) begin n_mis++; $display("FAIL byp_busy_before: got %b exp %b", rs_busy_a, 2'b11); end
        rf_en = 1'b1; rd = 5'd3; wdata = 64'h5A5A_5A5A_A5A5_A5A5;
        #1;
        n_cmp++; if (rdata_a !== {2{32'hA5A5_A5A5}}) begin n_mis++; $display("FAIL byp_rdata_a: got %h exp %h", rdata_a, {2{32'hA5A5_A5A5}}); end
        n_cmp++; if (rs_busy_a !== 2'b00) begin n_mis++; $display("FAIL byp_rs_busy_a: got %b exp %b", rs_busy_a, 2'b00); end
        n_cmp++; if (rdata_c !== {3{64'h5A5A_5A5A_A5A5_A5A5}}) begin n_mis++; $display("FAIL byp_rdata_c: got %h exp %h", rdata_c, {3{64'h5A5A_5A5A_A5A5_A5A5}}); end
        n_cmp++; if (rs_busy_c !== 3'b000) begin n_mis++; $display("FAIL byp_rs_busy_c: got %b exp %b", rs_busy_c, 3'b000); end
        n_cmp++; if (rdata_b !== 64'h0) begin n_mis++; $display("FAIL nobyp_rdata_b: got %h exp %h", rdata_b, 64'h0); end
        n_cmp++; if (rs_busy_b !== 2'b11) begin n_mis++; $display("FAIL nobyp_rs_busy_b: got %b exp %b", rs_busy_b, 2'b11); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (busy_vec_a[3] !== 1'b0) begin n_mis++; $display("FAIL byp_busy_clr: got %b exp %b", busy_vec_a[3], 1'b0); end
        n_cmp++; if (rdata_b !== {2{32'hA5A5_A5A5}}) begin n_mis++; $display("FAIL byp_stored_b: got %h exp %h", rdata_b, {2{32'hA5A5_A5A5}}); end
        @(negedge clk);
        $display("test_bypass done: compared=%0d mismatched=%0d", n_cmp, n_mis);
    endtask

    task automatic test_scoreboard();
        logic [63:0] w;
        w = {$urandom, $urandom};
        rs0 = 5'd9; rs1 = 5'd0; rs2 = 5'd9;
        issue_en = 1'b1; issue_rd = 5'd9;
        #1;
        n_cmp++; if (rs_busy_a[0] !== 1'b0) begin n_mis++; $display("FAIL sb_same_cycle: got %b exp %b", rs_busy_a[0], 1'b0); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (busy_vec_a[9] !== 1'b1) begin n_mis++; $display("FAIL sb_set_vec: got %b exp %b", busy_vec_a[9], 1'b1); end
        n_cmp++; if (rs_busy_a !== 2'b01) begin n_mis++; $display("FAIL sb_set_rs_a: got %b exp %b", rs_busy_a, 2'b01); end
        n_cmp++; if (rs_busy_c !== 3'b101) begin n_mis++; $display("FAIL sb_set_rs_c: got %b exp %b", rs_busy_c, 3'b101); end
        repeat (3) tick();
        rf_en = 1'b1; rd = 5'd9; wdata = w;
        #1;
        n_cmp++; if (rs_busy_a[0] !== 1'b0) begin n_mis++; $display("FAIL sb_wb_rs_a: got %b exp %b", rs_busy_a[0], 1'b0); end
        n_cmp++; if (rs_busy_b[0] !== 1'b1) begin n_mis++; $display("FAIL sb_wb_rs_b: got %b exp %b", rs_busy_b[0], 1'b1); end
        n_cmp++; if (rdata_c[127:64] !== 64'h0) begin n_mis++; $display("FAIL sb_r0_port1_c: got %h exp %h", rdata_c[127:64], 64'h0); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (busy_vec_a[9] !== 1'b0) begin n_mis++; $display("FAIL sb_clr_vec_a: got %b exp %b", busy_vec_a[9], 1'b0); end
        n_cmp++; if (busy_vec_c !== 16'h0) begin n_mis++; $display("FAIL sb_clr_vec_c: got %h exp %h", busy_vec_c, 16'h0); end
        n_cmp++; if (rdata_c[63:0] !== w) begin n_mis++; $display("FAIL sb_data_c: got %h exp %h", rdata_c[63:0], w); end
        @(negedge clk);
        $display("test_scoreboard done: compared=%0d mismatched=%0d", n_cmp, n_mis);
    endtask

    task automatic test_set_clear();
        logic [63:0] w;
        w = {$urandom, $urandom};
        rs0 = 5'd4; rs1 = 5'd0; rs2 = 5'd4;
        issue_en = 1'b1; issue_rd = 5'd4;
        tick();
        issue_en = 1'b1; issue_rd = 5'd4; rf_en = 1'b1; rd = 5'd4; wdata = w;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (busy_vec_a[4] !== 1'b1) begin n_mis++; $display("FAIL setclr_busy: got %b exp %b", busy_vec_a[4], 1'b1); end
        n_cmp++; if (rdata_b[31:0] !== w[31:0]) begin n_mis++; $display("FAIL setclr_data_b: got %h exp %h", rdata_b[31:0], w[31:0]); end
        n_cmp++; if (rdata_c[63:0] !== w) begin n_mis++; $display("FAIL setclr_data_c: got %h exp %h", rdata_c[63:0], w); end
        n_cmp++; if (rs_busy_b[0] !== 1'b1) begin n_mis++; $display("FAIL setclr_rs_b: got %b exp %b", rs_busy_b[0], 1'b1); end
        issue_en = 1'b1; issue_rd = 5'd0;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (busy_vec_a[0] !== 1'b0) begin n_mis++; $display("FAIL issue_r0_a: got %b exp %b", busy_vec_a[0], 1'b0); end
        n_cmp++; if (busy_vec_c[0] !== 1'b0) begin n_mis++; $display("FAIL issue_r0_c: got %b exp %b", busy_vec_c[0], 1'b0); end
        rf_en = 1'b1; rd = 5'd4; wdata = '0;
        tick();
        idle_inputs();
        $display("test_set_clear done: compared=%0d mismatched=%0d", n_cmp, n_mis);
    endtask

    task automatic test_top_reg();
        logic [63:0] w;
        w = {$urandom, $urandom};
        rs0 = 5'd15; rs1 = 5'd15; rs2 = 5'd15;
        issue_en = 1'b1; issue_rd = 5'd15;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (busy_vec_c[15] !== 1'b1) begin n_mis++; $display("FAIL top_busy: got %b exp %b", busy_vec_c[15], 1'b1); end
        n_cmp++; if (rs_busy_c !== 3'b111) begin n_mis++; $display("FAIL top_rs_busy: got %b exp %b", rs_busy_c, 3'b111); end
        rf_en = 1'b1; rd = 5'd15; wdata = w;
        #1;
        n_cmp++; if (rdata_c !== {3{w}}) begin n_mis++; $display("FAIL top_fwd: got %h exp %h", rdata_c, {3{w}}); end
        n_cmp++; if (rs_busy_c !== 3'b000) begin n_mis++; $display("FAIL top_rs_fwd: got %b exp %b", rs_busy_c, 3'b000); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rdata_c !== {3{w}}) begin n_mis++; $display("FAIL top_stored: got %h exp %h", rdata_c, {3{w}}); end
        n_cmp++; if (busy_vec_c[15] !== 1'b0) begin n_mis++; $display("FAIL top_clr: got %b exp %b", busy_vec_c[15], 1'b0); end
        @(negedge clk);
        $display("test_top_reg done: compared=%0d mismatched=%0d", n_cmp, n_mis);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rf_en    = ($urandom_range(0, 1) == 1);
            rd       = 5'($urandom_range(0, 31));
            wdata    = {$urandom, $urandom};
            issue_en = ($urandom_range(0, 2) == 0);
            issue_rd = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs0      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs1      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            #1;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (get_busy_vec(k) !== exp_busy_vec(k)) begin
                    n_mis++;
                    $display("FAIL rand_busy_vec cyc=%0d k=%0d: got %h exp %h", cyc, k, get_busy_vec(k), exp_busy_vec(k));
                end
                for (int p = 0; p < nrd(k); p++) begin
                    n_cmp++;
                    if (get_rdata(k, p) !== exp_rdata(k, p)) begin
                        n_mis++;
                        $display("FAIL rand_rdata cyc=%0d k=%0d p=%0d: got %h exp %h", cyc, k, p, get_rdata(k, p), exp_rdata(k, p));
                    end
                    n_cmp++;
                    if (get_rs_busy(k, p) !== exp_rs_busy(k, p)) begin
                        n_mis++;
                        $display("FAIL rand_rs_busy cyc=%0d k=%0d p=%0d: got %b exp %b", cyc, k, p, get_rs_busy(k, p), exp_rs_busy(k, p));
                    end
                end
            end
            tick();
        end
        idle_inputs();
        $display("test_random done: compared=%0d mismatched=%0d", n_cmp, n_mis);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        idle_inputs();
        rs0 = '0; rs1 = '0; rs2 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_set_clear();
        test_top_reg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the pipelined core, replacing the fixed 32x32 two-read-port file.
- Adds asynchronous reset clearing, configurable read-port count and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: decode/issue marks a destination pending, writeback clears it.
- Read ports report per-port hazard flags so the hazard unit can stall without its own tracking logic.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of independent read ports.
- BYPASS, 1, 1 = writeback data forwarded combinationally to matching read ports; 0 = no forwarding.
- (derived) AW = $clog2(NREGS).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- rf_en  in  1  writeback enable.
- rd  in  AW  writeback destination address.
- wdata  in  XLEN  writeback data.
- rs  in  NRD*AW  packed read addresses; port i = rs[i*AW +: AW].
- rdata  out  NRD*XLEN  packed read data; port i = rdata[i*XLEN +: XLEN].
- rs_busy  out  NRD  per-port hazard flag: source operand not yet available.
- issue_en  in  1  issue strobe: mark issue_rd as pending.
- issue_rd  in  AW  destination of the issuing instruction.
- busy_vec  out  NREGS  raw scoreboard bits; bit 0 always 0.

Behaviour:
- Reset is asynchronous and active-high: while rst=1 every register is forced to 0 and every busy bit to 0, independent of clk.
  - Consequence: rdata = 0, rs_busy = 0, busy_vec = 0 during and after reset until the first write.
  - rst deassertion mid-stream: the first rising edge with rst=0 performs normal updates.
- Register 0 is hardwired:
  - Reads return 0.
  - Writes are ignored; its busy bit is never set.
  - rs_busy for address 0 is always 0.
- Write:
  - On rising edge with rf_en=1 and rd!=0, reg[rd] <= wdata.
  - Visible to non-bypassed reads from the following cycle.
- Read: combinational, zero latency; each port is independent, and any two ports may address the same register.
- Bypass (BYPASS=1): when rf_en=1, rd!=0 and rd==rs[i], rdata[i] = wdata in the same cycle; otherwise rdata[i] = reg[rs[i]].
- Scoreboard update, at each rising edge and per register r != 0:
  - set = issue_en && issue_rd==r.
  - clr = rf_en && rd==r.
  - set=1 -> busy[r] <= 1 (set wins over a simultaneous clr: a new producer supersedes the retiring one).
  - else clr=1 -> busy[r] <= 0.
  - else hold.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Hazard flags:
  - BYPASS=1: rs_busy[i] = busy[rs[i]] && !(rf_en && rd==rs[i]); a same-cycle writeback resolves the hazard.
  - BYPASS=0: rs_busy[i] = busy[rs[i]].
- Issue and writeback never change a read result in the same cycle except via the bypass rule; a same-cycle issue does not raise rs_busy until the next cycle.
- Contains no X sources after reset; all outputs are defined for every input combination.
- Each port's read mux is a generate loop over NRD; the scoreboard is NREGS flops with per-bit set/clear logic.

Test Plan:
- Reset: write reg 5 = 0xDEADBEEF, assert rst asynchronously between edges -> rdata for rs=5 reads 0 immediately; busy_vec=0.
- Write/read: rf_en, rd=7, wdata=0x12345678, BYPASS=0 -> port 0 rs=7 reads old value that cycle, 0x12345678 the next. Write rd=0, wdata=0xFFFFFFFF -> reg 0 still reads 0.
- Bypass: BYPASS=1, rf_en, rd=3, wdata=0xA5A5A5A5, rs0=3, rs1=3 -> both ports show 0xA5A5A5A5 in the same cycle; rs_busy=0 even with busy[3]=1.
- Scoreboard lifecycle: issue_en, issue_rd=9 -> next cycle busy_vec[9]=1 and rs_busy[0]=1 for rs0=9. Three cycles later rf_en, rd=9 -> rs_busy[0]=0 that cycle (BYPASS=1); busy_vec[9]=0 after the edge.
- Simultaneous set/clear: issue_en, issue_rd=4 and rf_en, rd=4 on the same edge with busy[4]=1 -> busy[4]=1 afterwards, and reg[4] holds the new wdata. Issue to rd=0 -> busy_vec[0] stays 0.
- Parameter sweep: XLEN=64, NREGS=16, NRD=3 -> write/read/bypass/scoreboard scenarios above pass on all three ports, including the top register 15.
